// File: rtl/priority_demux_1to6_if.sv
// Bundle of source-side and sink-side signals for the 1-to-6 priority demux.
// The slave modport is the demux's view; the master modport is the environment's.
interface priority_demux_1to6_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic [WIDTH-1:0]     d_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           sel;
  logic [WIDTH-1:0]     d_out0;
  logic [WIDTH-1:0]     d_out1;
  logic [WIDTH-1:0]     d_out2;
  logic [WIDTH-1:0]     d_out3;
  logic [WIDTH-1:0]     d_out4;
  logic [WIDTH-1:0]     d_out5;
  logic [5:0]           out_valid;
  logic [5:0]           out_ready;
  logic [6*COUNT_W-1:0] count;

  modport slave (
    input  d_in, in_valid, sel, out_ready,
    output in_ready, d_out0, d_out1, d_out2, d_out3, d_out4, d_out5,
           out_valid, count
  );

  modport master (
    output d_in, in_valid, sel, out_ready,
    input  in_ready, d_out0, d_out1, d_out2, d_out3, d_out4, d_out5,
           out_valid, count
  );
endinterface

// File: rtl/priority_demux_1to6.sv
// Single-entry buffered 1-to-6 demux: one word is held until its priority-selected
// sink takes it, with a wrapping delivery counter per channel.
module priority_demux_1to6 #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  priority_demux_1to6_if.slave     bus
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  // sel[4] wins; no bit set routes to channel 0
  function automatic logic [2:0] decode_dest(input logic [4:0] s);
    logic [2:0] d;
    d = 3'd0;
    if      (s[4]) d = 3'd5;
    else if (s[3]) d = 3'd4;
    else if (s[2]) d = 3'd3;
    else if (s[1]) d = 3'd2;
    else if (s[0]) d = 3'd1;
    return d;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_data_p1;
  logic [2:0]         r_dest_p1;
  logic [COUNT_W-1:0] r_count [6];

  logic               w_load;
  logic               w_drain;
  logic               w_in_ready;
  logic [5:0]         w_out_valid;
  logic [5:0]         w_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drain     = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        w_drain    = bus.out_ready[r_dest_p1];
        w_in_ready = w_drain;
        if (w_drain) begin
          if (bus.in_valid) w_load      = 1'b1;
          else              w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // p0 -> p1: accept into the holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_data_p1 <= '0;
      r_dest_p1 <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data_p1 <= bus.d_in;
        r_dest_p1 <= decode_dest(bus.sel);
      end
    end
  end

  always_comb begin
    w_out_valid = '0;
    if (r_state == ST_FULL) w_out_valid[r_dest_p1] = 1'b1;
  end

  assign w_inc         = w_out_valid & bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.d_out0    = w_out_valid[0] ? r_data_p1 : '0;
  assign bus.d_out1    = w_out_valid[1] ? r_data_p1 : '0;
  assign bus.d_out2    = w_out_valid[2] ? r_data_p1 : '0;
  assign bus.d_out3    = w_out_valid[3] ? r_data_p1 : '0;
  assign bus.d_out4    = w_out_valid[4] ? r_data_p1 : '0;
  assign bus.d_out5    = w_out_valid[5] ? r_data_p1 : '0;

  // p1: delivery counters, wrapping naturally at 2^COUNT_W
  for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)            r_count[gi] <= '0;
      else if (w_inc[gi]) r_count[gi] <= r_count[gi] + 1'b1;
    end
    assign bus.count[gi*COUNT_W +: COUNT_W] = r_count[gi];
  end

endmodule
